// File: rtl/binary_decoder_seq.sv
// Registered valid/ready N-to-2^N one-hot decoder with a built-in walking-one scan.
// Optional parity checking on data_in is enabled by defining BINARY_DECODER_PARITY_EN.
module binary_decoder_seq #(
  parameter int WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  scan_start,
  output logic [2**WIDTH-1:0]   data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef BINARY_DECODER_PARITY_EN
  input  logic                  data_par,
  output logic                  par_err,
`endif
  output logic                  busy
);
  localparam int OUT_W = 2**WIDTH;

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  state_t             state, state_nx;
  logic [OUT_W-1:0]   data_nx, dec;
  logic               valid_nx;
  logic [WIDTH-1:0]   count, count_nx;
  logic               accept;

  assign in_ready = (state == IDLE && !scan_start) || (state == HOLD && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

`ifdef BINARY_DECODER_PARITY_EN
  logic par_nx, word_err;
  // Even parity: data_par must equal the XOR of the code bits.
  assign word_err = (data_par != ^data_in);
  assign dec      = word_err ? '0 : (OUT_W'(1) << data_in);
`else
  assign dec      = OUT_W'(1) << data_in;
`endif

  always_comb begin
    state_nx = state;
    data_nx  = data_out;
    valid_nx = out_valid;
    count_nx = count;
`ifdef BINARY_DECODER_PARITY_EN
    par_nx   = par_err;
`endif
    case (state)
      IDLE: begin
        if (scan_start) begin
          state_nx = SCAN;
          data_nx  = OUT_W'(1);
          valid_nx = 1'b1;
          count_nx = '0;
`ifdef BINARY_DECODER_PARITY_EN
          par_nx   = 1'b0;
`endif
        end else if (accept) begin
          state_nx = HOLD;
          data_nx  = dec;
          valid_nx = 1'b1;
`ifdef BINARY_DECODER_PARITY_EN
          par_nx   = word_err;
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (accept) begin
            data_nx  = dec;
`ifdef BINARY_DECODER_PARITY_EN
            par_nx   = word_err;
`endif
          end else begin
            state_nx = IDLE;
            data_nx  = '0;
            valid_nx = 1'b0;
`ifdef BINARY_DECODER_PARITY_EN
            par_nx   = 1'b0;
`endif
          end
        end
      end
      SCAN: begin
        if (out_ready) begin
          // Last bit consumed: drop back to IDLE rather than wrapping to bit 0.
          if (count == WIDTH'(OUT_W-1)) begin
            state_nx = IDLE;
            data_nx  = '0;
            valid_nx = 1'b0;
            count_nx = '0;
          end else begin
            data_nx  = data_out << 1;
            count_nx = count + WIDTH'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        data_nx  = '0;
        valid_nx = 1'b0;
        count_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_out  <= '0;
      out_valid <= 1'b0;
      count     <= '0;
`ifdef BINARY_DECODER_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      data_out  <= data_nx;
      out_valid <= valid_nx;
      count     <= count_nx;
`ifdef BINARY_DECODER_PARITY_EN
      par_err   <= par_nx;
`endif
    end
  end
endmodule

// File: tb/tb_binary_decoder_seq.sv
// Bench for binary_decoder_seq: directed steps then random traffic against a word-level model.
module tb_binary_decoder_seq;
  localparam int WIDTH = 3;
  localparam int OUT_W = 2**WIDTH;

  logic             clk, rst, in_valid, in_ready, scan_start, out_valid, out_ready, busy;
  logic [WIDTH-1:0] data_in;
  logic [OUT_W-1:0] data_out;
`ifdef BINARY_DECODER_PARITY_EN
  logic data_par, par_err;
  bit   auto_par = 1'b1;
`endif

  int errors = 0;
  int checks = 0;

  // Model: which word is presented (bit index), whether it comes from a scan, and its parity flag.
  bit m_valid = 0, m_scan = 0, m_perr = 0;
  int m_idx = 0;

  binary_decoder_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .scan_start(scan_start), .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
`ifdef BINARY_DECODER_PARITY_EN
    .data_par(data_par), .par_err(par_err),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] exp_word();
    if (!m_valid || m_perr) return '0;
    return OUT_W'(2**m_idx);
  endfunction

  // One clock: check in_ready on current inputs, advance model, check registered outputs.
  task automatic cycle();
    bit rdy, acc, perr;
    perr = 1'b0;
`ifdef BINARY_DECODER_PARITY_EN
    if (auto_par) data_par = logic'($countones(data_in) % 2);
    perr = (int'(data_par) != ($countones(data_in) % 2));
`endif
    rdy = (!m_valid && !scan_start) || (m_valid && !m_scan && out_ready);
    #0 chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    if (rst) begin
      m_valid = 0; m_scan = 0; m_perr = 0;
    end else if (!m_valid) begin
      if (scan_start) begin
        m_valid = 1; m_scan = 1; m_idx = 0; m_perr = 0;
      end else if (acc) begin
        m_valid = 1; m_scan = 0; m_idx = int'(data_in); m_perr = perr;
      end
    end else if (m_scan) begin
      if (out_ready) begin
        if (m_idx == OUT_W-1) begin m_valid = 0; m_scan = 0; end
        else m_idx++;
      end
    end else if (out_ready) begin
      if (acc) begin m_idx = int'(data_in); m_perr = perr; end
      else begin m_valid = 0; m_perr = 0; end
    end
    @(posedge clk); #1;
    chk("data_out", data_out, exp_word());
    chk("out_valid", out_valid, m_valid);
    chk("busy", busy, m_valid);
`ifdef BINARY_DECODER_PARITY_EN
    chk("par_err", par_err, m_valid && m_perr);
`endif
  endtask

  initial begin
    rst = 1; in_valid = 1; data_in = 3'd7; scan_start = 0; out_ready = 1;
`ifdef BINARY_DECODER_PARITY_EN
    data_par = 0;
`endif
    // Reset held two cycles with a pending input.
    @(posedge clk); #1;
    cycle();
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 0; in_valid = 0;
    #1 chk("rst_in_ready", in_ready, 1'b1);

    // Single decode then drain.
    data_in = 3'd5; in_valid = 1; out_ready = 1;
    cycle();
    chk("single_data", data_out, 8'b0010_0000);
    in_valid = 0;
    cycle();
    chk("single_drain", out_valid, 1'b0);

    // Back-to-back stream.
    in_valid = 1;
    for (int i = 0; i < OUT_W; i++) begin
      data_in = WIDTH'(i);
      cycle();
      chk("stream", data_out, OUT_W'(1) << i);
    end
    in_valid = 0;
    cycle();

    // Backpressure holds the word and blocks input.
    data_in = 3'd2; in_valid = 1;
    cycle();
    data_in = 3'd6; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold", data_out, 8'h04);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1;
    cycle();
    chk("bp_next", data_out, 8'h40);
    in_valid = 0;
    cycle();

    // Scan beats a same-cycle input.
    scan_start = 1; in_valid = 1; data_in = 3'd3;
    #1 chk("scan_prio_ready", in_ready, 1'b0);
    cycle();
    chk("scan_first", data_out, 8'h01);
    scan_start = 0;
    for (int i = 1; i < OUT_W; i++) begin
      cycle();
      chk("scan_walk", data_out, OUT_W'(1) << i);
    end
    cycle();
    chk("scan_end", out_valid, 1'b0);
    in_valid = 0;

    // Scan with toggling out_ready.
    scan_start = 1;
    cycle();
    scan_start = 0;
    for (int k = 0; k < 100 && m_valid; k++) begin
      out_ready = $urandom_range(0, 1);
      cycle();
    end
    chk("scan_toggle_done", m_valid, 1'b0);
    out_ready = 1;

    // Reset in the middle of a scan, then restart.
    scan_start = 1;
    cycle();
    scan_start = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("mid_scan_word", data_out, 8'h08);
    rst = 1;
    cycle();
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_valid", out_valid, 1'b0);
    rst = 0; scan_start = 1;
    cycle();
    chk("restart", data_out, 8'h01);
    scan_start = 0;
    for (int i = 0; i < OUT_W; i++) cycle();

`ifdef BINARY_DECODER_PARITY_EN
    // Bad parity yields a zero word flagged with par_err.
    auto_par = 0; data_in = 3'd3; data_par = 1; in_valid = 1;
    cycle();
    chk("par_data", data_out, 8'h00);
    chk("par_valid", out_valid, 1'b1);
    chk("par_err", par_err, 1'b1);
    in_valid = 0;
    cycle();
    chk("par_clear", par_err, 1'b0);
`endif

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      in_valid   = $urandom_range(0, 1);
      data_in    = WIDTH'($urandom);
      scan_start = ($urandom_range(0, 9) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
`ifdef BINARY_DECODER_PARITY_EN
      data_par   = $urandom_range(0, 1);
`endif
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
